// File: rtl/arm_pkg.sv
// Shared types and constants for the memory stage: FSM state encoding,
// datapath widths and the byte-to-word address helper.
package arm_pkg;

  localparam int DATA_W        = 32;
  localparam int REG_ADDR_W    = 4;
  localparam int DEF_ADDR_BASE = 1024;
  localparam int CNT_W         = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } mem_state_t;

  // Offset from the SRAM base, wrapping modulo 2^32, expressed in words.
  function automatic logic [DATA_W-1:0] byte_to_word(input logic [DATA_W-1:0] byte_addr,
                                                     input logic [DATA_W-1:0] base);
    return (byte_addr - base) >> 2;
  endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Single-port SRAM sequencer: latches one access, holds the strobes for
// WAIT_CYCLES cycles, captures the read word and stalls the pipeline meanwhile.
module sram_ctrl
  import arm_pkg::*;
#(
  parameter int ADDR_BASE   = DEF_ADDR_BASE,
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_CYCLES = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_r_en_in,
  input  logic                  mem_w_en_in,
  input  logic [DATA_W-1:0]     alu_result_in,
  input  logic [DATA_W-1:0]     val_rm_in,
  input  logic [DATA_W-1:0]     sram_rdata,
  output logic                  ready,
  output logic                  done,
  output logic [DATA_W-1:0]     rd_word,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_W-1:0]     sram_wdata,
  output logic                  sram_we,
  output logic                  sram_oe
);

  mem_state_t            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W-1:0]     r_rd_word;
  logic                  r_we;
  logic                  r_oe;
  logic                  w_mem_op;

  assign w_mem_op = mem_r_en_in | mem_w_en_in;

  // Stall is combinational so the requesting instruction freezes in its own cycle.
  assign ready = rst | (r_state == DONE) | ((r_state == IDLE) & ~w_mem_op);
  assign done  = (r_state == DONE);

  assign rd_word    = r_rd_word;
  assign sram_addr  = r_addr;
  assign sram_wdata = r_wdata;
  assign sram_we    = r_we;
  assign sram_oe    = r_oe;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rd_word <= '0;
      r_we      <= 1'b0;
      r_oe      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_mem_op) begin
            r_addr  <= ADDR_WIDTH'(byte_to_word(alu_result_in, DATA_W'(ADDR_BASE)));
            r_wdata <= val_rm_in;
            r_cnt   <= CNT_W'(WAIT_CYCLES - 1);
            // A request with both enables set is serviced as a load only.
            r_oe    <= mem_r_en_in;
            r_we    <= ~mem_r_en_in;
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_cnt == '0) begin
            r_rd_word <= r_oe ? sram_rdata : '0;
            r_we      <= 1'b0;
            r_oe      <= 1'b0;
            r_state   <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: SRAM sequencer plus the MEM/WB register,
// which takes bubbles while the access is in flight.
module mem_stage
  import arm_pkg::*;
#(
  parameter int ADDR_BASE   = DEF_ADDR_BASE,
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_CYCLES = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_en_in,
  input  logic                  mem_r_en_in,
  input  logic                  mem_w_en_in,
  input  logic [DATA_W-1:0]     alu_result_in,
  input  logic [DATA_W-1:0]     val_rm_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  output logic                  ready,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_W-1:0]     sram_wdata,
  input  logic [DATA_W-1:0]     sram_rdata,
  output logic                  sram_we,
  output logic                  sram_oe,
  output logic                  wb_en,
  output logic                  mem_r_en,
  output logic [DATA_W-1:0]     alu_result,
  output logic [DATA_W-1:0]     mem_data,
  output logic [REG_ADDR_W-1:0] dest
);

  logic                  w_done;
  logic [DATA_W-1:0]     w_rd_word;
  logic                  r_wb_en;
  logic                  r_mem_r_en;
  logic [DATA_W-1:0]     r_alu_result;
  logic [DATA_W-1:0]     r_mem_data;
  logic [REG_ADDR_W-1:0] r_dest;

  sram_ctrl #(
    .ADDR_BASE  (ADDR_BASE),
    .ADDR_WIDTH (ADDR_WIDTH),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_sram_ctrl (
    .clk          (clk),
    .rst          (rst),
    .mem_r_en_in  (mem_r_en_in),
    .mem_w_en_in  (mem_w_en_in),
    .alu_result_in(alu_result_in),
    .val_rm_in    (val_rm_in),
    .sram_rdata   (sram_rdata),
    .ready        (ready),
    .done         (w_done),
    .rd_word      (w_rd_word),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_we      (sram_we),
    .sram_oe      (sram_oe)
  );

  // ready is high only in IDLE without a request or in DONE; otherwise insert a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_en      <= 1'b0;
      r_mem_r_en   <= 1'b0;
      r_alu_result <= '0;
      r_mem_data   <= '0;
      r_dest       <= '0;
    end else if (ready) begin
      r_wb_en      <= wb_en_in;
      r_mem_r_en   <= mem_r_en_in;
      r_alu_result <= alu_result_in;
      r_mem_data   <= w_done ? w_rd_word : '0;
      r_dest       <= dest_in;
    end else begin
      r_wb_en    <= 1'b0;
      r_mem_r_en <= 1'b0;
    end
  end

  assign wb_en      = r_wb_en;
  assign mem_r_en   = r_mem_r_en;
  assign alu_result = r_alu_result;
  assign mem_data   = r_mem_data;
  assign dest       = r_dest;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: a transaction-level model (word memory,
// expected stall length, strobe counts and latency) checks two instances.
module tb_mem_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sel;
  logic        wb_en_i, r_i, w_i;
  logic [31:0] alu_i, rm_i;
  logic [3:0]  dest_i;
  logic [31:0] sram_rdata;

  logic        d0_ready, d0_we, d0_oe, d0_wb, d0_mr;
  logic [15:0] d0_addr;
  logic [31:0] d0_wdata, d0_alu, d0_md;
  logic [3:0]  d0_dest;
  logic        d1_ready, d1_we, d1_oe, d1_wb, d1_mr;
  logic [15:0] d1_addr;
  logic [31:0] d1_wdata, d1_alu, d1_md;
  logic [3:0]  d1_dest;

  mem_stage #(.ADDR_BASE(1024), .ADDR_WIDTH(16), .WAIT_CYCLES(5)) u_dut0 (
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en_i & ~sel), .mem_r_en_in(r_i & ~sel), .mem_w_en_in(w_i & ~sel),
    .alu_result_in(sel ? 32'd0 : alu_i), .val_rm_in(sel ? 32'd0 : rm_i),
    .dest_in(sel ? 4'd0 : dest_i),
    .ready(d0_ready), .sram_addr(d0_addr), .sram_wdata(d0_wdata), .sram_rdata(sram_rdata),
    .sram_we(d0_we), .sram_oe(d0_oe), .wb_en(d0_wb), .mem_r_en(d0_mr),
    .alu_result(d0_alu), .mem_data(d0_md), .dest(d0_dest)
  );

  mem_stage #(.ADDR_BASE(1024), .ADDR_WIDTH(16), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en_i & sel), .mem_r_en_in(r_i & sel), .mem_w_en_in(w_i & sel),
    .alu_result_in(sel ? alu_i : 32'd0), .val_rm_in(sel ? rm_i : 32'd0),
    .dest_in(sel ? dest_i : 4'd0),
    .ready(d1_ready), .sram_addr(d1_addr), .sram_wdata(d1_wdata), .sram_rdata(sram_rdata),
    .sram_we(d1_we), .sram_oe(d1_oe), .wb_en(d1_wb), .mem_r_en(d1_mr),
    .alu_result(d1_alu), .mem_data(d1_md), .dest(d1_dest)
  );

  // View of whichever instance is currently exercised.
  logic        v_ready, v_we, v_oe, v_wb, v_mr;
  logic [15:0] v_addr;
  logic [31:0] v_wdata, v_alu, v_md;
  logic [3:0]  v_dest;
  always_comb begin
    v_ready = sel ? d1_ready : d0_ready;
    v_we    = sel ? d1_we    : d0_we;
    v_oe    = sel ? d1_oe    : d0_oe;
    v_wb    = sel ? d1_wb    : d0_wb;
    v_mr    = sel ? d1_mr    : d0_mr;
    v_addr  = sel ? d1_addr  : d0_addr;
    v_wdata = sel ? d1_wdata : d0_wdata;
    v_alu   = sel ? d1_alu   : d0_alu;
    v_md    = sel ? d1_md    : d0_md;
    v_dest  = sel ? d1_dest  : d0_dest;
  end

  // Environment SRAM model and the reference model's own view of memory.
  logic [31:0] sram_mem [0:65535];
  logic [31:0] ref_mem  [0:65535];
  assign sram_rdata = v_oe ? sram_mem[v_addr] : 32'h0BAD_F00D;
  always @(posedge clk) if (v_we) sram_mem[v_addr] <= v_wdata;

  int n_chk = 0;
  int n_err = 0;

  logic        exp_wb, exp_mr;
  logic [31:0] exp_alu, exp_md;
  logic [3:0]  exp_dest;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] word_of(input logic [31:0] a);
    int unsigned off;
    off = a - 32'd1024;
    return 16'((off / 4) % 65536);
  endfunction

  // Called 1 time unit after a rising edge; returns at the same phase.
  task automatic run_op(input bit wb, input bit r, input bit w, input logic [31:0] alu,
                        input logic [31:0] rm, input logic [3:0] d, input int wc);
    int          e, n_low, n_we, n_oe, c;
    bit          bub_ok, strobe_ok, mem;
    logic [15:0] wa;
    logic [31:0] data;
    mem = r | w;
    wa  = word_of(alu);
    data = 32'd0;
    wb_en_i = wb; r_i = r; w_i = w; alu_i = alu; rm_i = rm; dest_i = d;
    if (!mem) begin
      @(negedge clk);
      chk("alu_ready", 32'(v_ready), 32'd1);
      chk("alu_strobe", 32'({v_we, v_oe}), 32'd0);
      @(posedge clk); #1;
      e = 1;
    end else begin
      if (r) data = ref_mem[wa];
      e = 0; n_low = 0; n_we = 0; n_oe = 0; bub_ok = 1; strobe_ok = 1;
      for (c = 0; c < 64; c++) begin
        @(negedge clk);
        if (c == 0) begin
          chk("req_ready_low", 32'(v_ready), 32'd0);
          chk("req_strobe_idle", 32'({v_we, v_oe}), 32'd0);
        end
        if (v_ready) break;
        n_low++;
        if (v_we) begin
          n_we++;
          if (v_addr !== wa || v_wdata !== rm) strobe_ok = 0;
        end
        if (v_oe) begin
          n_oe++;
          if (v_addr !== wa) strobe_ok = 0;
        end
        if (v_we && v_oe) strobe_ok = 0;
        if (e >= 1 && (v_wb !== 1'b0 || v_mr !== 1'b0 || v_alu !== exp_alu || v_dest !== exp_dest))
          bub_ok = 0;
        @(posedge clk); e++; #1;
      end
      if (c == 64) chk("timeout_ready", 32'(v_ready), 32'd1);
      @(posedge clk); e++; #1;
      chk("ready_low_cycles", n_low, wc + 1);
      chk("we_cycles", n_we, (w && !r) ? wc : 0);
      chk("oe_cycles", n_oe, r ? wc : 0);
      chk("strobe_addr_data", 32'(strobe_ok), 32'd1);
      chk("bubble", 32'(bub_ok), 32'd1);
      chk("latency", e, wc + 2);
      if (w && !r) ref_mem[wa] = rm;
    end
    exp_wb = wb; exp_mr = r; exp_alu = alu; exp_dest = d; exp_md = data;
    chk("wb_en", 32'(v_wb), 32'(exp_wb));
    chk("mem_r_en", 32'(v_mr), 32'(exp_mr));
    chk("alu_result", v_alu, exp_alu);
    chk("mem_data", v_md, exp_md);
    chk("dest", 32'(v_dest), 32'(exp_dest));
    $display("op dut%0d wb=%0d r=%0d w=%0d alu=%h rm=%h dest=%0d -> word=%h edges=%0d mem_data=%h",
             sel, wb, r, w, alu, rm, d, wa, e, v_md);
  endtask

  task automatic clear_exp();
    exp_wb = 0; exp_mr = 0; exp_alu = 0; exp_md = 0; exp_dest = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          k;
    logic [31:0] a;
    for (int i = 0; i < 65536; i++) begin
      sram_mem[i] = $urandom;
      ref_mem[i]  = sram_mem[i];
    end
    sel = 0; rst = 1;
    wb_en_i = 0; r_i = 0; w_i = 0; alu_i = 0; rm_i = 0; dest_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(v_ready), 32'd1);
    chk("rst_strobes", 32'({v_we, v_oe}), 32'd0);
    chk("rst_outputs", {v_wb, v_mr, v_alu[3:0], v_md[3:0], v_dest}, 32'd0);
    chk("rst_alu", v_alu, 32'd0);
    rst = 0;
    clear_exp();

    run_op(1, 0, 0, 32'h55, 32'h0, 4'd3, 5);
    run_op(0, 0, 1, 32'd1032, 32'hDEADBEEF, 4'd5, 5);
    run_op(1, 1, 0, 32'd1032, 32'h0, 4'd7, 5);
    run_op(1, 1, 0, 32'd1036, 32'h0, 4'd8, 5);
    run_op(0, 0, 1, 32'd1040, 32'h1234_5678, 4'd9, 5);
    run_op(1, 1, 0, 32'd1040, 32'h0, 4'd10, 5);
    run_op(0, 0, 1, 32'd1016, 32'hA5A5_5A5A, 4'd11, 5);
    run_op(1, 1, 0, 32'd1016, 32'h0, 4'd12, 5);
    run_op(1, 1, 1, 32'd1033, 32'hFFFF_FFFF, 4'd13, 5);

    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 3);
      a = 32'd1024 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      if (k == 0) a = $urandom;
      run_op(1'($urandom_range(0, 1)), (k == 1 || k == 3), (k == 2 || k == 3),
             a, $urandom, 4'($urandom_range(0, 15)), 5);
    end

    // Reset during the third ACCESS cycle of a load.
    run_op(1, 0, 0, 32'h1234, 32'h0, 4'd6, 5);
    wb_en_i = 1; r_i = 1; w_i = 0; alu_i = 32'd1044; rm_i = 0; dest_i = 4'd9;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_oe", 32'(v_oe), 32'd1);
    rst = 1;
    @(posedge clk); #1;
    chk("midrst_strobes", 32'({v_we, v_oe}), 32'd0);
    chk("midrst_ready", 32'(v_ready), 32'd1);
    chk("midrst_alu", v_alu, 32'd0);
    chk("midrst_ctl", {v_wb, v_mr, v_md[7:0], v_dest}, 32'd0);
    chk("midrst_mem_data", v_md, 32'd0);
    rst = 0;
    wb_en_i = 0; r_i = 0; w_i = 0; alu_i = 0; dest_i = 0;
    @(negedge clk);
    chk("postrst_idle_ready", 32'(v_ready), 32'd1);
    chk("postrst_strobes", 32'({v_we, v_oe}), 32'd0);
    @(posedge clk); #1;
    clear_exp();

    // Single-wait-cycle instance; both enables high must act as a load.
    sel = 1;
    run_op(1, 1, 1, 32'd1052, 32'hCAFE_F00D, 4'd2, 1);
    for (int i = 0; i < 10; i++) begin
      k = $urandom_range(0, 3);
      a = 32'd1024 + 32'($urandom_range(0, 15) * 4);
      run_op(1'($urandom_range(0, 1)), (k == 1 || k == 3), (k == 2 || k == 3),
             a, $urandom, 4'($urandom_range(0, 15)), 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
